// File: rtl/arrow_lanes_pkg.sv
// Shared types and default geometry for the arrow_lanes rhythm-game block.
// Slot y is stored at SLOT_YW bits, so CORDW must not exceed SLOT_YW.
package arrow_pkg;

   localparam int DEF_CORDW      = 10;
   localparam int DEF_LANES      = 4;
   localparam int DEF_SLOTS      = 4;
   localparam int DEF_ARROW_SIZE = 16;
   localparam int DEF_LANE_X0    = 0;
   localparam int DEF_LANE_PITCH = 32;
   localparam int DEF_SPAWN_Y    = 464;
   localparam int DEF_TARGET_Y   = 32;
   localparam int DEF_HIT_WIN    = 8;
   localparam int DEF_SPEED_W    = 3;
   localparam int SLOT_YW        = 16;
   localparam int SCORE_W        = 16;

   typedef struct packed {
      logic               active;
      logic [SLOT_YW-1:0] y;
   } slot_t;

   function automatic logic [SCORE_W-1:0] sat_add16(input logic [SCORE_W-1:0] a,
                                                    input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/arrow_lanes_lane.sv
// One lane of arrows: slot storage, spawn, per-frame scroll, press judgement
// and pixel coverage. All outputs except ready_o are registered.
module arrow_lane
   import arrow_pkg::*;
#(
   parameter int CORDW      = DEF_CORDW,
   parameter int SLOTS      = DEF_SLOTS,
   parameter int ARROW_SIZE = DEF_ARROW_SIZE,
   parameter int LANE_X0    = DEF_LANE_X0,
   parameter int LANE_PITCH = DEF_LANE_PITCH,
   parameter int SPAWN_Y    = DEF_SPAWN_Y,
   parameter int TARGET_Y   = DEF_TARGET_Y,
   parameter int HIT_WIN    = DEF_HIT_WIN,
   parameter int SPEED_W    = DEF_SPEED_W,
   parameter int LANE_IDX   = 0
) (
   input  logic               clk_pix,
   input  logic               rst_pix,
   input  logic               frame_i,
   input  logic [SPEED_W-1:0] speed_i,
   input  logic               spawn_i,
   input  logic               press_i,
   input  logic [CORDW-1:0]   sx_i,
   input  logic [CORDW-1:0]   sy_i,
   output logic               ready_o,
   output logic               arrow_o,
   output logic               hit_o,
   output logic               miss_o
);

   // Arithmetic is one bit wider than stored y so box edges never wrap.
   localparam int W = SLOT_YW + 1;
   localparam logic [W-1:0]       XL      = W'(LANE_X0 + LANE_IDX * LANE_PITCH);
   localparam logic [W-1:0]       AS      = W'(ARROW_SIZE);
   localparam logic [W-1:0]       TGT     = W'(TARGET_Y);
   localparam logic [W-1:0]       WIN     = W'(HIT_WIN);
   localparam logic [SLOT_YW-1:0] SPAWN_V = SLOT_YW'(SPAWN_Y);

   slot_t       slot_q [SLOTS];
   slot_t       slot_d [SLOTS];
   logic        press_q, press_d;
   logic        init_q, init_d;
   logic        hit_q, hit_d;
   logic        miss_q, miss_d;
   logic        arrow_q, arrow_d;
   logic        free_s;
   logic        press_edge_s;
   logic [W-1:0] yv_s;
   logic [W-1:0] sx_w_s;
   logic [W-1:0] sy_w_s;
   logic [W-1:0] spd_s;

   assign sx_w_s = W'(sx_i);
   assign sy_w_s = W'(sy_i);
   assign spd_s  = W'(speed_i);

   // Next-state for slots plus judgement and coverage, all from pre-update state.
   always_comb begin
      slot_d       = slot_q;
      press_d      = press_i;
      init_d       = 1'b0;
      hit_d        = 1'b0;
      miss_d       = 1'b0;
      arrow_d      = 1'b0;
      free_s       = 1'b0;
      yv_s         = '0;
      press_edge_s = ~init_q & press_i & ~press_q;
      for (int i = 0; i < SLOTS; i++) begin
         yv_s = {1'b0, slot_q[i].y};
         if (slot_q[i].active && (XL <= sx_w_s) && (sx_w_s <= XL + AS) &&
             (yv_s <= sy_w_s) && (sy_w_s <= yv_s + AS)) begin
            arrow_d = 1'b1;
         end else begin
            arrow_d = arrow_d;
         end
         if (!slot_q[i].active) begin
            if (!free_s) begin
               free_s = 1'b1;
               if (spawn_i) begin
                  slot_d[i] = '{active: 1'b1, y: SPAWN_V};
               end else begin
                  slot_d[i] = slot_q[i];
               end
            end else begin
               slot_d[i] = slot_q[i];
            end
         end else if (press_edge_s && !hit_d && (yv_s + WIN >= TGT) && (yv_s <= TGT + WIN)) begin
            // A judged slot leaves before the scroll, so it cannot also miss.
            slot_d[i].active = 1'b0;
            hit_d            = 1'b1;
         end else if (frame_i) begin
            if ((yv_s < spd_s) || ((yv_s - spd_s + WIN) < TGT)) begin
               slot_d[i].active = 1'b0;
               miss_d           = 1'b1;
            end else begin
               slot_d[i].y = slot_q[i].y - SLOT_YW'(speed_i);
            end
         end else begin
            slot_d[i] = slot_q[i];
         end
      end
   end

   // State registers; init_q makes the first post-reset cycle load press history only.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         slot_q  <= '{default: '0};
         press_q <= 1'b0;
         init_q  <= 1'b1;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         arrow_q <= 1'b0;
      end else begin
         slot_q  <= slot_d;
         press_q <= press_d;
         init_q  <= init_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         arrow_q <= arrow_d;
      end
   end

   assign ready_o = free_s;
   assign arrow_o = arrow_q;
   assign hit_o   = hit_q;
   assign miss_o  = miss_q;

endmodule

// File: rtl/arrow_lanes.sv
// Multi-lane falling-arrow engine: LANES copies of arrow_lane plus an optional
// saturating hit score enabled by the macro ARROW_LANES_SCORE_EN.
module arrow_lanes
   import arrow_pkg::*;
#(
   parameter int CORDW      = DEF_CORDW,
   parameter int LANES      = DEF_LANES,
   parameter int SLOTS      = DEF_SLOTS,
   parameter int ARROW_SIZE = DEF_ARROW_SIZE,
   parameter int LANE_X0    = DEF_LANE_X0,
   parameter int LANE_PITCH = DEF_LANE_PITCH,
   parameter int SPAWN_Y    = DEF_SPAWN_Y,
   parameter int TARGET_Y   = DEF_TARGET_Y,
   parameter int HIT_WIN    = DEF_HIT_WIN,
   parameter int SPEED_W    = DEF_SPEED_W
) (
   input  logic                     clk_pix,
   input  logic                     rst_pix,
   input  logic                     frame_i,
   input  logic [SPEED_W-1:0]       speed_i,
   input  logic                     spawn_valid_i,
   output logic                     spawn_ready_o,
   input  logic [$clog2(LANES)-1:0] spawn_lane_i,
   input  logic [LANES-1:0]         press_i,
   input  logic [CORDW-1:0]         sx_i,
   input  logic [CORDW-1:0]         sy_i,
   output logic [LANES-1:0]         arrow_o,
   output logic [LANES-1:0]         hit_o,
   output logic [LANES-1:0]         miss_o,
   output logic [SCORE_W-1:0]       score_o
);

   localparam int LANE_W = $clog2(LANES);

   logic [LANES-1:0] lane_ready_s;
   logic             ready_s;

   // Readiness of the addressed lane only.
   always_comb begin
      ready_s = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         if (spawn_lane_i == LANE_W'(l)) begin
            ready_s = lane_ready_s[l];
         end else begin
            ready_s = ready_s;
         end
      end
   end

   assign spawn_ready_o = ready_s;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      arrow_lane #(
         .CORDW      (CORDW),
         .SLOTS      (SLOTS),
         .ARROW_SIZE (ARROW_SIZE),
         .LANE_X0    (LANE_X0),
         .LANE_PITCH (LANE_PITCH),
         .SPAWN_Y    (SPAWN_Y),
         .TARGET_Y   (TARGET_Y),
         .HIT_WIN    (HIT_WIN),
         .SPEED_W    (SPEED_W),
         .LANE_IDX   (l)
      ) u_lane (
         .clk_pix (clk_pix),
         .rst_pix (rst_pix),
         .frame_i (frame_i),
         .speed_i (speed_i),
         .spawn_i (spawn_valid_i && ready_s && (spawn_lane_i == LANE_W'(l))),
         .press_i (press_i[l]),
         .sx_i    (sx_i),
         .sy_i    (sy_i),
         .ready_o (lane_ready_s[l]),
         .arrow_o (arrow_o[l]),
         .hit_o   (hit_o[l]),
         .miss_o  (miss_o[l])
      );
   end

`ifdef ARROW_LANES_SCORE_EN
   logic [SCORE_W-1:0] score_q, score_d;
   logic [SCORE_W-1:0] hits_s;

   // Score grows by the number of lanes judged a hit in the visible hit_o.
   always_comb begin
      hits_s = '0;
      for (int l = 0; l < LANES; l++) begin
         hits_s = hits_s + {{(SCORE_W-1){1'b0}}, hit_o[l]};
      end
      score_d = sat_add16(score_q, hits_s);
   end

   // Score register.
   always_ff @(posedge clk_pix or posedge rst_pix) begin
      if (rst_pix) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score_o = score_q;
`else
   assign score_o = {SCORE_W{1'b0}};
`endif

endmodule

// File: tb/tb_arrow_lanes.sv
// Randomised and directed bench for arrow_lanes against a behavioural lane model.
module tb_arrow_lanes;

   localparam int LANES = 4, SLOTS = 4, AS = 16, X0 = 0, PITCH = 32;
   localparam int SPAWN_Y = 464, TARGET_Y = 32, HIT_WIN = 8;

   logic        clk_pix = 1'b0;
   logic        rst_pix = 1'b1;
   logic        frame_i = 1'b0;
   logic [2:0]  speed_i = 3'd0;
   logic        spawn_valid_i = 1'b0;
   logic        spawn_ready_o;
   logic [1:0]  spawn_lane_i = 2'd0;
   logic [3:0]  press_i = 4'd0;
   logic [9:0]  sx_i = 10'd0;
   logic [9:0]  sy_i = 10'd0;
   logic [3:0]  arrow_o, hit_o, miss_o;
   logic [15:0] score_o;

   int total = 0;
   int bad = 0;

   int m_act [LANES][SLOTS];
   int m_y   [LANES][SLOTS];
   logic [3:0] m_prev, m_hit, m_miss, m_arrow;
   int m_init;
   int m_score;

   arrow_lanes #(
      .CORDW(10), .LANES(LANES), .SLOTS(SLOTS), .ARROW_SIZE(AS), .LANE_X0(X0),
      .LANE_PITCH(PITCH), .SPAWN_Y(SPAWN_Y), .TARGET_Y(TARGET_Y), .HIT_WIN(HIT_WIN),
      .SPEED_W(3)
   ) dut (
      .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_i(frame_i), .speed_i(speed_i),
      .spawn_valid_i(spawn_valid_i), .spawn_ready_o(spawn_ready_o),
      .spawn_lane_i(spawn_lane_i), .press_i(press_i), .sx_i(sx_i), .sy_i(sy_i),
      .arrow_o(arrow_o), .hit_o(hit_o), .miss_o(miss_o), .score_o(score_o)
   );

   always #5 clk_pix = ~clk_pix;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic model_ready(input int lane);
      logic r = 1'b0;
      for (int i = 0; i < SLOTS; i++) if (m_act[lane][i] == 0) r = 1'b1;
      return r;
   endfunction

   function automatic int lane_count(input int lane);
      int n = 0;
      for (int i = 0; i < SLOTS; i++) n += m_act[lane][i];
      return n;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < LANES; l++)
         for (int i = 0; i < SLOTS; i++) begin
            m_act[l][i] = 0;
            m_y[l][i] = 0;
         end
      m_prev = 4'd0; m_hit = 4'd0; m_miss = 4'd0; m_arrow = 4'd0;
      m_init = 1; m_score = 0;
   endtask

   // One clock of the game rules, from the inputs currently applied.
   task automatic model_step();
      logic [3:0] nh = 4'd0, nm = 4'd0, na = 4'd0;
      int spd = int'(speed_i);
      int sx = int'(sx_i);
      int sy = int'(sy_i);
      for (int l = 0; l < LANES; l++) begin
         int x = X0 + l * PITCH;
         int sp = -1;
         for (int i = 0; i < SLOTS; i++) begin
            if (m_act[l][i] == 0 && sp < 0) sp = i;
            if (m_act[l][i] != 0 && x <= sx && sx <= x + AS && m_y[l][i] <= sy && sy <= m_y[l][i] + AS)
               na[l] = 1'b1;
         end
         if (m_init == 0 && press_i[l] && !m_prev[l]) begin
            for (int i = 0; i < SLOTS; i++) begin
               int d = m_y[l][i] - TARGET_Y;
               if (d < 0) d = -d;
               if (m_act[l][i] != 0 && d <= HIT_WIN && !nh[l]) begin
                  m_act[l][i] = 0;
                  nh[l] = 1'b1;
               end
            end
         end
         if (frame_i) begin
            for (int i = 0; i < SLOTS; i++) begin
               if (m_act[l][i] != 0) begin
                  if (m_y[l][i] < spd || m_y[l][i] - spd < TARGET_Y - HIT_WIN) begin
                     m_act[l][i] = 0;
                     nm[l] = 1'b1;
                  end else begin
                     m_y[l][i] = m_y[l][i] - spd;
                  end
               end
            end
         end
         if (spawn_valid_i && int'(spawn_lane_i) == l && sp >= 0) begin
            m_act[l][sp] = 1;
            m_y[l][sp] = SPAWN_Y;
         end
      end
`ifdef ARROW_LANES_SCORE_EN
      m_score = m_score + $countones(m_hit);
      if (m_score > 65535) m_score = 65535;
`else
      m_score = 0;
`endif
      m_hit = nh; m_miss = nm; m_arrow = na;
      m_prev = press_i;
      m_init = 0;
   endtask

   // Called just after a falling edge with inputs applied; returns at the next falling edge.
   task automatic cycle();
      #1;
      chk("spawn_ready", spawn_ready_o, model_ready(int'(spawn_lane_i)));
      model_step();
      @(posedge clk_pix); #1;
      chk("arrow_o", arrow_o, m_arrow);
      chk("hit_o", hit_o, m_hit);
      chk("miss_o", miss_o, m_miss);
      chk("score_o", score_o, 64'(m_score));
      @(negedge clk_pix);
   endtask

   task automatic do_reset();
      rst_pix = 1'b1;
      #1;
      chk("rst_arrow", arrow_o, 64'd0);
      chk("rst_hit", hit_o, 64'd0);
      chk("rst_miss", miss_o, 64'd0);
      chk("rst_score", score_o, 64'd0);
      chk("rst_ready", spawn_ready_o, 64'd1);
      @(posedge clk_pix);
      @(negedge clk_pix);
      rst_pix = 1'b0;
      model_reset();
   endtask

   task automatic spawn(input int lane);
      spawn_valid_i = 1'b1;
      spawn_lane_i = 2'(lane);
      cycle();
      spawn_valid_i = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         frame_i = 1'b1; cycle();
         frame_i = 1'b0; cycle();
      end
   endtask

   initial begin
      model_reset();
      @(negedge clk_pix);
      do_reset();

      // Hit at y=40 in lane 2.
      speed_i = 3'd4;
      spawn(2);
      frames(106);
      chk("pin_y40", 64'(m_y[2][0]), 64'd40);
      press_i = 4'b0100; cycle();
      chk("hit_lane2", hit_o, 64'h4);
      press_i = 4'b0000; cycle();
      chk("hit_pulse_end", hit_o, 64'h0);
      chk("lane2_freed", 64'(lane_count(2)), 64'd0);

      // Miss in lane 0 after frame 111.
      do_reset();
      spawn(0);
      frames(110);
      chk("pin_y24", 64'(m_y[0][0]), 64'd24);
      frame_i = 1'b1; cycle();
      chk("miss_lane0", miss_o, 64'h1);
      frame_i = 1'b0; cycle();
      chk("miss_pulse_end", miss_o, 64'h0);
      chk("lane0_freed", 64'(lane_count(0)), 64'd0);

      // Full lane back-pressure.
      do_reset();
      for (int k = 0; k < 4; k++) spawn(1);
      spawn_lane_i = 2'd1; #1;
      chk("ready_lane1_full", spawn_ready_o, 64'd0);
      spawn_lane_i = 2'd3; #1;
      chk("ready_lane3", spawn_ready_o, 64'd1);
      spawn_lane_i = 2'd1; spawn_valid_i = 1'b1; cycle();
      spawn_valid_i = 1'b0;
      chk("fifth_ignored", 64'(lane_count(1)), 64'd4);

      // Box coverage for lane 3 at y=100.
      do_reset();
      spawn(3);
      frames(91);
      chk("pin_y100", 64'(m_y[3][0]), 64'd100);
      sy_i = 10'd100;
      for (int x = 96; x <= 113; x++) begin
         sx_i = 10'(x); cycle();
      end
      chk("arrow_sx113", arrow_o[3], 64'd0);
      sx_i = 10'd112; sy_i = 10'd116; cycle();
      chk("arrow_corner", arrow_o[3], 64'd1);
      sx_i = 10'd96; sy_i = 10'd99; cycle();
      chk("arrow_above", arrow_o[3], 64'd0);

      // Press and frame together at y=24.
      do_reset();
      spawn(2);
      frames(110);
      press_i = 4'b0100; frame_i = 1'b1; cycle();
      chk("hit_with_frame", hit_o, 64'h4);
      chk("no_miss_with_hit", miss_o, 64'h0);
      press_i = 4'b0000; frame_i = 1'b0; cycle();
      chk("no_late_miss", miss_o, 64'h0);

      // Two lanes hit together, then reset mid-scroll.
      do_reset();
      spawn(0); spawn(3);
      frames(106);
      press_i = 4'b1001; cycle();
      chk("hit_two_lanes", hit_o, 64'h9);
      press_i = 4'b0000; cycle();
`ifdef ARROW_LANES_SCORE_EN
      chk("score_plus2", score_o, 64'd2);
`else
      chk("score_off", score_o, 64'd0);
`endif
      spawn(1); spawn(2);
      frames(50);
      press_i = 4'hF;
      do_reset();
      frames(130);
      press_i = 4'h0;

      // Randomised traffic with one reset in the middle.
      for (int c = 0; c < 3000; c++) begin
         frame_i = ($urandom_range(0, 2) == 0);
         speed_i = 3'($urandom_range(0, 7));
         spawn_valid_i = ($urandom_range(0, 3) == 0);
         spawn_lane_i = 2'($urandom_range(0, 3));
         for (int l = 0; l < LANES; l++)
            if ($urandom_range(0, 3) == 0) press_i[l] = ~press_i[l];
         sx_i = 10'($urandom_range(0, 140));
         sy_i = 10'($urandom_range(0, 480));
         if (c == 1500) begin
            press_i = 4'hF;
            do_reset();
         end
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
